// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle RV32I load/store unit between the ALU result
// path and a variable-latency data memory.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of silently aligning them.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ls_valid,
    input  logic        ls_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ls_stall,
    output logic        ls_done,
    output logic        ls_err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg;
    logic [2:0]  f3_reg;
    logic [1:0]  lane_reg;

    logic        legal, misalign, accept_ok;
    logic [3:0]  be_dec;
    logic [31:0] wd_dec;
    logic        ack_hit, timeout_hit;
    logic [7:0]  rd_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    assign ls_stall = ls_valid & ~ls_done;
    assign ls_done  = (state_reg == DONE);

    // Decode width, byte enables, replicated store data and legality of the request
    always_comb begin
        be_dec   = '0;
        wd_dec   = '0;
        misalign = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                be_dec = 4'b0001 << addr[1:0];
                wd_dec = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_dec = addr[1] ? 4'b1100 : 4'b0011;
                wd_dec = {2{wdata[15:0]}};
            end
            2'b10: begin
                be_dec = 4'b1111;
                wd_dec = wdata;
            end
            default: begin
                be_dec = '0;
                wd_dec = '0;
            end
        endcase
        // Loads never drive meaningful write data onto the bus
        if (!ls_write) begin
            wd_dec = '0;
        end
        if (ls_write) begin
            legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
        end else begin
            legal = (funct3[1:0] != 2'b11) && (funct3 != 3'b110);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    assign accept_ok   = legal & ~misalign;
    assign ack_hit     = (state_reg == REQ) && mem_ack;
    assign timeout_hit = (state_reg == REQ) && !mem_ack &&
                         (cnt_reg == 8'(TIMEOUT_CYCLES - 1));

    // Split the returned word into byte lanes for extraction
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    // Select and extend the addressed lane according to the latched load type
    always_comb begin
        sel_byte = rd_byte[lane_reg];
        sel_half = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_reg)
            3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_ext = {24'd0, sel_byte};
            3'b101:  load_ext = {16'd0, sel_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: errors detected at decode skip the memory phase
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (ls_valid) begin
                    state_next = accept_ok ? REQ : DONE;
                end
            end
            REQ: begin
                if (ack_hit || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory bus, timeout counter, error flag and load result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg   <= '0;
            f3_reg    <= '0;
            lane_reg  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ls_err    <= 1'b0;
            rdata     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ls_valid) begin
                        f3_reg   <= funct3;
                        lane_reg <= addr[1:0];
                        cnt_reg  <= '0;
                        if (accept_ok) begin
                            mem_req   <= 1'b1;
                            mem_we    <= ls_write;
                            mem_be    <= be_dec;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= wd_dec;
                            ls_err    <= 1'b0;
                        end else begin
                            ls_err <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (ack_hit || timeout_hit) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        ls_err    <= timeout_hit;
                        if (ack_hit && !mem_we) begin
                            rdata <= load_ext;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                DONE: begin
                    ls_err <= 1'b0;
                end
                default: begin
                    ls_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit.
// Expected completions and memory requests are queued by the stimulus and
// popped by a monitor whenever the DUT presents ls_done or a new mem_req.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ls_valid = 1'b0;
    logic        ls_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ls_stall, ls_done, ls_err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .ls_valid(ls_valid), .ls_write(ls_write), .funct3(funct3),
        .addr(addr), .wdata(wdata),
        .ls_stall(ls_stall), .ls_done(ls_done), .ls_err(ls_err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rd;
    } done_exp_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
    } mem_exp_t;

    done_exp_t done_q[$];
    mem_exp_t  mem_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic mem_req_d = 1'b0;

    // Monitor: checks every completion and the first cycle of every memory request
    always @(negedge clk) begin
        done_exp_t de;
        mem_exp_t  me;
        if (rst) begin
            if (ls_done) begin
                n_cmp++;
                if (done_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_done: got ls_done=1 err=%0b rdata=%h, required no completion", ls_err, rdata);
                end else begin
                    de = done_q.pop_front();
                    if (ls_err !== de.err || rdata !== de.rd) begin
                        n_bad++;
                        $display("FAIL done_resp: got err=%0b rdata=%h, required err=%0b rdata=%h", ls_err, rdata, de.err, de.rd);
                    end
                end
                n_cmp++;
                if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
                    n_bad++;
                    $display("FAIL bus_idle_at_done: got req=%0b we=%0b be=%b addr=%h wd=%h, required all zero", mem_req, mem_we, mem_be, mem_addr, mem_wdata);
                end
            end
            if (mem_req && !mem_req_d) begin
                n_cmp++;
                if (mem_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_req: got mem_req=1 addr=%h, required no request", mem_addr);
                end else begin
                    me = mem_q.pop_front();
                    if (mem_we !== me.we || mem_be !== me.be || mem_addr !== me.addr || mem_wdata !== me.wd) begin
                        n_bad++;
                        $display("FAIL mem_req_fields: got we=%0b be=%b addr=%h wd=%h, required we=%0b be=%b addr=%h wd=%h",
                                 mem_we, mem_be, mem_addr, mem_wdata, me.we, me.be, me.addr, me.wd);
                    end
                end
            end
        end
        mem_req_d = mem_req;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // One transaction: ack_wait = REQ cycles before ack (-1 = never ack)
    task automatic access(input string name, input bit w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                          input int ack_wait, input bit exp_err, input logic [31:0] exp_rd,
                          input bit exp_mem, input logic [3:0] exp_be,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wd);
        int lat, reqc, exp_lat, exp_reqc;
        lat  = 0;
        reqc = 0;
        done_q.push_back('{err: exp_err, rd: exp_rd});
        if (exp_mem) mem_q.push_back('{we: w, be: exp_be, addr: exp_addr, wd: exp_wd});
        exp_lat  = !exp_mem ? 1 : (ack_wait >= 0 ? 2 + ack_wait : TMO + 1);
        exp_reqc = !exp_mem ? 0 : (ack_wait >= 0 ? ack_wait + 1 : TMO);
        @(negedge clk);
        ls_valid = 1'b1; ls_write = w; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (ls_done) begin
                lat = k;
                break;
            end
            if (mem_req) begin
                if (ack_wait >= 0 && reqc == ack_wait) begin
                    mem_ack = 1'b1;
                    mem_rdata = mrd;
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = 32'hBAD0BAD0;
                end
                reqc++;
            end else begin
                mem_ack = 1'b0;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_req_cycles"}, 32'(reqc), 32'(exp_reqc));
        check({name, "_stall_at_done"}, {31'd0, ls_stall}, 32'd0);
        $display("txn %s: we=%0b f3=%b addr=%h latency=%0d req_cycles=%0d err=%0b rdata=%h",
                 name, w, f3, a, lat, reqc, ls_err, rdata);
        ls_valid = 1'b0;
        mem_ack  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        check("reset_req",   {31'd0, mem_req}, 32'd0);
        check("reset_done",  {30'd0, ls_done, ls_err}, 32'd0);
        check("reset_be_we", {27'd0, mem_be, mem_we}, 32'd0);
        check("reset_addr",  mem_addr, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        access("sw_100",  1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0, 32'h0, 1'b1, 4'b1111, 32'h100, 32'hDEADBEEF);
        access("sb_103",  1'b1, 3'b000, 32'h103, 32'h0000005A, 32'h0, 1, 1'b0, 32'h0, 1'b1, 4'b1000, 32'h100, 32'h5A5A5A5A);
        access("lb_103",  1'b0, 3'b000, 32'h103, 32'h0, 32'h5A000000, 0, 1'b0, 32'h0000005A, 1'b1, 4'b1000, 32'h100, 32'h0);
        access("lh_202",  1'b0, 3'b001, 32'h202, 32'h0, 32'h80010000, 2, 1'b0, 32'hFFFF8001, 1'b1, 4'b1100, 32'h200, 32'h0);
        access("lhu_202", 1'b0, 3'b101, 32'h202, 32'h0, 32'h80010000, 0, 1'b0, 32'h00008001, 1'b1, 4'b1100, 32'h200, 32'h0);
        access("lw_tmo",  1'b0, 3'b010, 32'h300, 32'h0, 32'h0, -1, 1'b1, 32'h00008001, 1'b1, 4'b1111, 32'h300, 32'h0);
        access("ld_f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b1, 32'h00008001, 1'b0, 4'b0000, 32'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        access("lw_102",  1'b0, 3'b010, 32'h102, 32'h0, 32'h12345678, 0, 1'b1, 32'h00008001, 1'b0, 4'b0000, 32'h0, 32'h0);
`else
        access("lw_102",  1'b0, 3'b010, 32'h102, 32'h0, 32'h12345678, 0, 1'b0, 32'h12345678, 1'b1, 4'b1111, 32'h100, 32'h0);
`endif
        access("lb_101",  1'b0, 3'b000, 32'h101, 32'h0, 32'h00008000, 1, 1'b0, 32'hFFFFFF80, 1'b1, 4'b0010, 32'h100, 32'h0);
        access("lbu_102", 1'b0, 3'b100, 32'h102, 32'h0, 32'h00AB0000, 0, 1'b0, 32'h000000AB, 1'b1, 4'b0100, 32'h100, 32'h0);
        access("sh_206",  1'b1, 3'b001, 32'h206, 32'h1234CAFE, 32'h0, 0, 1'b0, 32'h000000AB, 1'b1, 4'b1100, 32'h204, 32'hCAFECAFE);
        access("st_f3_100", 1'b1, 3'b100, 32'h000, 32'h11111111, 32'h0, 0, 1'b1, 32'h000000AB, 1'b0, 4'b0000, 32'h0, 32'h0);

        // Stray ack with no request outstanding must not complete anything
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_ack_req", {30'd0, mem_req, ls_done}, 32'd0);

        // Reset asserted mid-REQ with ack withheld
        mem_q.push_back('{we: 1'b0, be: 4'b1111, addr: 32'h500, wd: 32'h0});
        @(negedge clk);
        ls_valid = 1'b1; ls_write = 1'b0; funct3 = 3'b010; addr = 32'h500; wdata = 32'h0;
        @(posedge clk);
        repeat (2) @(negedge clk);
        check("mid_req_pre", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_req",  {30'd0, mem_req, ls_done}, 32'd0);
        check("rst_async_bus",  {27'd0, mem_be, mem_we} | mem_addr | mem_wdata, 32'd0);
        check("rst_async_data", rdata, 32'd0);
        ls_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        $display("txn rst_mid_req: mem_req=%0b ls_done=%0b after reset release", mem_req, ls_done);

        access("lw_400",  1'b0, 3'b010, 32'h400, 32'h0, 32'hA5A50F0F, 3, 1'b0, 32'hA5A50F0F, 1'b1, 4'b1111, 32'h400, 32'h0);

        repeat (3) @(negedge clk);
        check("done_q_empty", 32'(done_q.size()), 32'd0);
        check("mem_q_empty",  32'(mem_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
